// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues data-memory accesses, stalls the front of the
// pipe until ack or timeout, and registers the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_stage_if.master  dmem,
  input  logic [63:0]         ALU_data,
  input  logic [63:0]         rd_data,
  input  logic [7:0]          branch_target,
  input  logic                zero,
  input  logic                branch,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                MemtoReg,
  input  logic                regwrite,
  input  logic [4:0]          EX_MEM_rd,
  output logic                PCsrc,
  output logic [7:0]          pc_branch,
  output logic                mem_stall,
  output logic                mem_err,
  output logic [4:0]          MEM_WB_rd,
  output logic                regwrite_out,
  output logic                MemtoReg_out,
  output logic [63:0]         read_data_out,
  output logic [63:0]         ALU_data_out
);
  localparam int CW = $clog2(DMEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [63:0] wb_rdata_q, wb_rdata_d;
  logic [63:0] wb_alu_q, wb_alu_d;

  logic memop;
  logic rw_ok;
  logic stall;
  logic req;

  assign memop = MemRead | MemWrite;
  assign rw_ok = regwrite & (EX_MEM_rd != 5'd0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    stall         = 1'b0;
    req           = 1'b0;
    // Default load is a bubble; real instructions overwrite below.
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    wb_rd_d       = 5'd0;
    wb_rdata_d    = 64'd0;
    wb_alu_d      = 64'd0;

    case (state_q)
      S_IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          wb_regwrite_d = rw_ok;
          wb_memtoreg_d = MemtoReg;
          wb_rd_d       = EX_MEM_rd;
          wb_alu_d      = ALU_data;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack) begin
          wb_regwrite_d = rw_ok;
          wb_memtoreg_d = MemtoReg;
          wb_rd_d       = EX_MEM_rd;
          wb_alu_d      = ALU_data;
          wb_rdata_d    = MemWrite ? 64'd0 : dmem.dmem_rdata;
          state_d       = S_IDLE;
        end else if (cnt_q == CW'(DMEM_TIMEOUT - 1)) begin
          // Abort: let the instruction retire without a register write.
          err_d         = 1'b1;
          wb_memtoreg_d = MemtoReg;
          wb_rd_d       = EX_MEM_rd;
          wb_alu_d      = ALU_data;
          state_d       = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      stall = 1'b0;
      req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_rdata_q    <= 64'd0;
      wb_alu_q      <= 64'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_rd_q       <= wb_rd_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_alu_q      <= wb_alu_d;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & MemWrite;
  assign dmem.dmem_addr  = ALU_data;
  assign dmem.dmem_wdata = rd_data;

  assign PCsrc         = branch & zero;
  assign pc_branch     = branch_target;
  assign mem_stall     = stall;
  assign mem_err       = err_q;
  assign MEM_WB_rd     = wb_rd_q;
  assign regwrite_out  = wb_regwrite_q;
  assign MemtoReg_out  = wb_memtoreg_q;
  assign read_data_out = wb_rdata_q;
  assign ALU_data_out  = wb_alu_q;
endmodule
